// File: rtl/sms_power_sbox_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : sms_power_sbox_seq_if
// Description : Operand/result handshake bundle for the sequential power S-box.
// Revision    : 1.0 - initial release
// ============================================================================
interface sms_power_sbox_seq_if #(
  parameter int N = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;

  modport master (
    output in_valid,
    output x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y
  );

  modport slave (
    input  in_valid,
    input  x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y
  );
endinterface
`default_nettype wire

// File: rtl/sms_power_sbox_seq.sv
`default_nettype none
// ============================================================================
// Module      : sms_power_sbox_seq
// Description : Handshaked GF(2^N) power map y = x^EXP, one exponent bit per
//               cycle (left-to-right square-and-multiply). Define SMS_AFFINE_EN
//               to XOR in the broadcast parity term parity(x & ADD_MASK).
// Revision    : 1.0 - initial release
// ============================================================================
module sms_power_sbox_seq #(
  parameter int           N        = 6,
  parameter int           EXP      = 19,
  parameter logic [N:0]   POLY     = 7'b1000011,
  parameter logic [N-1:0] ADD_MASK = 6'b010100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sms_power_sbox_seq_if.slave       bus
);

  localparam int           c_EXP_W    = $clog2(EXP + 1);
  localparam int           c_IDX_W    = (c_EXP_W > 1) ? $clog2(c_EXP_W) : 1;
  localparam logic [c_EXP_W-1:0] c_EXP_BITS = c_EXP_W'(EXP);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_EXP_W - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [N-1:0] c_POLY_LO  = POLY[N-1:0];
  localparam logic [N-1:0] c_ONE      = {{(N-1){1'b0}}, 1'b1};

  localparam logic [1:0]   c_S_IDLE   = 2'd0;
  localparam logic [1:0]   c_S_RUN    = 2'd1;
  localparam logic [1:0]   c_S_DONE   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [N-1:0]       r_x;
  logic [N-1:0]       r_acc;
  logic [c_IDX_W-1:0] r_idx;
  logic [N-1:0]       r_y;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic [N-1:0]       w_sq;
  logic [N-1:0]       w_step;
  logic [N-1:0]       w_affine;

  // Carry-less product, MSB-first Horner form with reduction on every shift.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] p;
    p = '0;
    for (int i = N - 1; i >= 0; i--) begin
      p = {p[N-2:0], 1'b0} ^ (p[N-1] ? c_POLY_LO : {N{1'b0}});
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (w_accept)        w_state_nxt = c_S_RUN;
      c_S_RUN:  if (r_idx == '0)     w_state_nxt = c_S_DONE;
      c_S_DONE: if (bus.out_ready)   w_state_nxt = w_accept ? c_S_RUN : c_S_IDLE;
      default:                       w_state_nxt = c_S_IDLE;
    endcase
  end

  // A result leaving DONE frees the engine in the same cycle, so in_ready
  // follows out_ready there to allow back-to-back operands.
  always_comb begin
    w_in_ready  = (r_state == c_S_IDLE) | ((r_state == c_S_DONE) & bus.out_ready);
    w_out_valid = (r_state == c_S_DONE);
  end

  assign w_accept = bus.in_valid & w_in_ready;

  always_comb begin
    w_sq   = gf_mul(r_acc, r_acc);
    w_step = c_EXP_BITS[r_idx] ? gf_mul(w_sq, r_x) : w_sq;
  end

`ifdef SMS_AFFINE_EN
  assign w_affine = {N{^(r_x & ADD_MASK)}};
`else
  // Folds to zero; the mask stays referenced but produces no logic.
  assign w_affine = ADD_MASK & {N{1'b0}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_acc <= '0;
      r_idx <= '0;
      r_y   <= '0;
    end else if (w_accept) begin
      r_x   <= bus.x;
      r_acc <= c_ONE;
      r_idx <= c_IDX_LAST;
    end else if (r_state == c_S_RUN) begin
      r_acc <= w_step;
      r_idx <= r_idx - c_IDX_ONE;
      if (r_idx == '0) r_y <= w_step ^ w_affine;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.y         = r_y;

endmodule
`default_nettype wire

// File: tb/tb_sms_power_sbox_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sms_power_sbox_seq
// Description : Scoreboard bench for sms_power_sbox_seq (GF(2^6) defaults and a
//               GF(2^8) inverse instance). Honours SMS_AFFINE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sms_power_sbox_seq;

  typedef struct {
    logic [7:0] val;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t sb6[$];
  exp_t sb8[$];
  int   rise6[$];
  logic ov6_q = 1'b0;
  logic ov8_q = 1'b0;

  sms_power_sbox_seq_if #(.N(6)) b6 ();
  sms_power_sbox_seq_if #(.N(8)) b8 ();

  sms_power_sbox_seq u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b6.slave)
  );

  sms_power_sbox_seq #(
    .N        (8),
    .EXP      (254),
    .POLY     (9'h11B),
    .ADD_MASK (8'h00)
  ) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Reference arithmetic: LSB-first shift-and-add with per-shift reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b,
                                      input int n, input logic [8:0] poly);
    logic [8:0] aa;
    logic [7:0] r;
    aa = {1'b0, a};
    r  = '0;
    for (int i = 0; i < n; i++) begin
      if (b[i]) r = r ^ aa[7:0];
      aa = aa << 1;
      if (aa[n]) aa = aa ^ poly;
    end
    return r;
  endfunction

  function automatic logic [7:0] model6(input logic [7:0] xv);
    logic [7:0] r;
    r = 8'h01;
    repeat (19) r = gmul(r, xv, 6, 9'h043);
`ifdef SMS_AFFINE_EN
    if (^(xv[5:0] & 6'b010100)) r = r ^ 8'h3F;
`endif
    return r;
  endfunction

  function automatic logic [7:0] inv8(input logic [7:0] xv);
    for (int c = 1; c < 256; c++)
      if (gmul(xv, 8'(c), 8, 9'h11B) == 8'h01) return 8'(c);
    return 8'h00;
  endfunction

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b6.out_valid && !ov6_q) begin
        rise6.push_back(cyc);
        if (sb6.size() == 0) fail_now("n6_spurious_valid");
        else chk("n6_latency", 32'(cyc - sb6[0].acc), 32'd5);
      end
      if (b6.out_valid && b6.out_ready) begin
        if (sb6.size() == 0) fail_now("n6_unexpected_out");
        else begin
          e = sb6.pop_front();
          chk("n6_y", {26'd0, b6.y}, {24'd0, e.val});
        end
      end
    end
    ov6_q <= b6.out_valid & rst_n;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b8.out_valid && !ov8_q) begin
        if (sb8.size() == 0) fail_now("n8_spurious_valid");
        else chk("n8_latency", 32'(cyc - sb8[0].acc), 32'd8);
      end
      if (b8.out_valid && b8.out_ready) begin
        if (sb8.size() == 0) fail_now("n8_unexpected_out");
        else begin
          e = sb8.pop_front();
          chk("n8_y", {24'd0, b8.y}, {24'd0, e.val});
        end
      end
    end
    ov8_q <= b8.out_valid & rst_n;
  end

  // ---------------------------------------------------------------- drivers
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send6(input logic [5:0] xv, input logic [7:0] req);
    bit ok;
    exp_t e;
    ok = 0;
    b6.in_valid = 1'b1;
    b6.x        = xv;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (b6.in_ready) ok = 1;
    end
    if (!ok) fail_now("n6_accept_timeout");
    else begin
      e.val = req;
      e.acc = cyc + 1;
      sb6.push_back(e);
    end
    @(posedge clk);
    #1;
    b6.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] xv, input logic [7:0] req);
    bit ok;
    exp_t e;
    ok = 0;
    b8.in_valid = 1'b1;
    b8.x        = xv;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (b8.in_ready) ok = 1;
    end
    if (!ok) fail_now("n8_accept_timeout");
    else begin
      e.val = req;
      e.acc = cyc + 1;
      sb8.push_back(e);
    end
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      if (sb6.size() == 0 && sb8.size() == 0) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) fail_now("drain_timeout");
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [7:0] y_x04;
  bit         seen;

  initial begin
`ifdef SMS_AFFINE_EN
    y_x04 = 8'h24;
`else
    y_x04 = 8'h1B;
`endif
    b6.in_valid = 1'b0; b6.x = '0; b6.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.x = '0; b8.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  {31'd0, b6.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, b6.out_valid}, 32'd0);
    chk("rst_y",         {26'd0, b6.y},         32'd0);
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived results.
    send6(6'h02, 8'h1E);
    drain(40);
    send6(6'h04, y_x04);
    drain(40);
    send6(6'h00, 8'h00);
    drain(40);
    send6(6'h01, 8'h01);
    drain(40);

    // Backpressure: result held under out_ready=0 while a new operand waits.
    b6.out_ready = 1'b0;
    send6(6'h04, y_x04);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (b6.out_valid) seen = 1;
    end
    if (!seen) fail_now("bp_valid_timeout");
    b6.in_valid = 1'b1;
    b6.x        = 6'h3F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_y_hold",     {24'd0, 2'b00, b6.y}, {24'd0, y_x04});
      chk("bp_in_ready",   {31'd0, b6.in_ready},  32'd0);
      chk("bp_out_valid",  {31'd0, b6.out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    b6.in_valid  = 1'b0;
    b6.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_single_xfer", {31'd0, b6.out_valid}, 32'd0);
    chk("bp_queue_empty", 32'(sb6.size()), 32'd0);

    // Reset in the middle of RUN discards the in-flight result.
    send6(6'h04, y_x04);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, b6.out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, b6.in_ready},  32'd1);
    chk("mid_rst_y",         {26'd0, b6.y},         32'd0);
    sb6.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send6(6'h02, 8'h1E);
    drain(40);

    // Chaining through DONE with in_valid/out_ready held high.
    rise6.delete();
    send6(6'h01, 8'h01);
    send6(6'h02, 8'h1E);
    send6(6'h04, y_x04);
    drain(60);
    chk("chain_count", 32'(rise6.size()), 32'd3);
    if (rise6.size() == 3) begin
      chk("chain_gap1", 32'(rise6[1] - rise6[0]), 32'd6);
      chk("chain_gap2", 32'(rise6[2] - rise6[1]), 32'd6);
    end

    // Exhaustive sweeps against the software models.
    for (int v = 0; v < 64; v++) send6(6'(v), model6(8'(v)));
    drain(200);
    for (int v = 0; v < 256; v++) send8(8'(v), inv8(8'(v)));
    drain(200);

    chk("final_sb6_empty", 32'(sb6.size()), 32'd0);
    chk("final_sb8_empty", 32'(sb8.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sms_power_sbox_seq.md
# sms_power_sbox_seq

Sequential, parametrised power-map S-box engine for GF(2^N) in polynomial basis: computes y = x^EXP, optionally XORed with a broadcast linear parity term, by iterative left-to-right square-and-multiply, one exponent bit per cycle. It is the area-reduced, handshaked successor to the fixed 6-bit combinational power-19 S-boxes. It sits between the S-box characterisation harness and the multi-cycle datapaths that cannot afford a full combinational exponentiation tree.

## Interface
- N, 6: field width in bits; N ≥ 2.
- EXP, 19: exponent; 1 ≤ EXP ≤ 2^N−2.
- POLY, 7'b1000011: irreducible polynomial, N+1 bits, bit N set (default x^6+x+1).
- ADD_MASK, 6'b010100: N-bit selection mask for the affine parity term.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand x valid.
- in_ready  output  1  engine can accept x.
- x  input  N  operand, polynomial basis, bit 0 = constant coefficient.
- out_valid  output  1  y valid.
- out_ready  input  1  consumer accepts y.
- y  output  N  result.

## Operation
- Derived constant: EXP_W = number of significant bits of EXP (EXP=19 → 5).
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch x into x_r, acc←1, bit index←EXP_W−1, go to RUN.
- RUN: each cycle acc←acc²·(EXP[idx] ? x_r : 1) mod POLY; idx decrements. After the step at idx=0, register y and go to DONE.
- DONE: out_valid=1, y stable. On out_ready: out_valid drops. If in_valid is also high in the same cycle, the new x is accepted (in_ready=1 in DONE while out_ready=1) and the engine goes directly to RUN. Otherwise it goes to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready); no acceptance in RUN.
- Arithmetic: squaring and multiplication are carry-less, with reduction by POLY each step; acc never exceeds N bits.
- Affine term: t = XOR-reduce(x_r & ADD_MASK); y = acc ⊕ {N{t}}.
- x=0 yields acc=0, which is mathematically exact (EXP≥1).
- x input is ignored unless accepted; x_r holds across RUN.
- Reset mid-operation: state←IDLE, the in-flight result is discarded, and no spurious out_valid is produced.

## Timing
- Reset values: in_ready=1 after reset releases (IDLE), out_valid=0, y=0; internal acc=0, x_r=0.
- Latency: acceptance edge k; RUN steps on edges k+1..k+EXP_W; out_valid is high from edge k+EXP_W (default: 5 cycles after acceptance).
- Throughput with out_ready held high: one result per EXP_W+1 cycles, using the DONE→RUN chaining path.
- out_valid/y hold indefinitely under out_ready=0; y never changes while out_valid=1.
- in_ready depends combinationally on out_ready only in DONE; there is no other combinational input-to-output path.

## Configuration
- SMS_AFFINE_EN defined: y = x^EXP ⊕ {N{parity(x & ADD_MASK)}}.
- SMS_AFFINE_EN undefined: y = x^EXP; ADD_MASK is unused and the parity logic is not synthesised.
- Latency and handshake are identical in both builds.

## Test plan
- Reset: assert rst_n=0 mid-RUN -> out_valid=0, in_ready=1, y=0 immediately; after release, the next operand completes normally.
- Defaults with SMS_AFFINE_EN, x=6'h02 -> y=6'h1E (α^19, t=0) exactly 5 cycles after acceptance; x=6'h04 -> y=6'h24 (α^38=6'h1B, t=1).
- Without SMS_AFFINE_EN, x=6'h04 -> y=6'h1B; x=6'h00 -> 6'h00; x=6'h01 -> 6'h01.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> y stable, in_ready=0, in_valid ignored; release -> single transfer.
- Chaining: in_valid and out_ready held high with a stream of x=1,2,4 -> results 6'h01, 6'h1E, 6'h24 at 6-cycle spacing, none dropped or duplicated.
- Exhaustive sweep of all 64 inputs (defaults) against a software GF(2^6) model -> bit-exact match; N=8, EXP=254, POLY=9'h11B sweep -> y is the field inverse (0→0).
